// File: rtl/execute_mdu_seq.sv
// execute_mdu_seq: multi-cycle RV64M multiply/divide sequencer for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per CALC cycle.
// Optional macro MDU_EARLY_OUT_EN: multiply leaves CALC once the remaining
// multiplier bits are all zero (divide timing unchanged, results identical).
module execute_mdu_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic               accept, a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, special_result;
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] mul_acc, div_acc, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;
  logic               last_iter, early_out;

  // Decode the offered op: signedness, magnitudes and the divide special cases
  always_comb begin
    a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU) || (in_op == OP_DIV) || (in_op == OP_REM);
    b_signed = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
    a_neg    = a_signed && in_a[WIDTH-1];
    b_neg    = b_signed && in_b[WIDTH-1];
    a_mag    = a_neg ? -in_a : in_a;
    b_mag    = b_neg ? -in_b : in_b;
    is_div   = in_op[2];
    div_zero = is_div && (in_b == '0);
    div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_a == MIN_VAL) && (in_b == '1);
    if (div_zero) special_result = in_op[1] ? in_a : '1;
    else          special_result = in_op[1] ? '0 : in_a;
  end

  // One iteration of each algorithm plus the final sign fix-up and result select
  always_comb begin
    mul_acc = mplier[0] ? (acc + mcand) : acc;
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, mcand[WIDTH-1:0]};
    if (!diff[WIDTH]) div_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else              div_acc = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    last_iter = (cnt == CNT_W'(WIDTH-1));
`ifdef MDU_EARLY_OUT_EN
    early_out = !op_q[2] && (mplier[WIDTH-1:1] == '0);
`else
    early_out = 1'b0;
`endif
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (op_q[2])              fix_result = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == OP_MUL)  fix_result = prod_fix[WIDTH-1:0];
    else                      fix_result = prod_fix[2*WIDTH-1:WIDTH];
  end

  // Next-state logic and handshake/stall outputs
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    accept     = in_valid && in_ready && !flush;
    stall      = (state == CALC) || (state == FIX) || ((state == IDLE) && in_valid && !flush);
    case (state)
      IDLE:    if (accept) state_next = (div_zero || div_ovf) ? DONE : CALC;
      CALC:    if (last_iter || early_out) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Operand latch, per-bit iteration and result register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      out_result <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= in_op;
      neg_q <= (is_div && in_op[1]) ? a_neg : (a_neg ^ b_neg);
      if (is_div) begin
        acc    <= {{WIDTH{1'b0}}, a_mag};
        mcand  <= {{WIDTH{1'b0}}, b_mag};
        mplier <= '0;
      end else begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
      end
      if (div_zero || div_ovf) out_result <= special_result;
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (op_q[2]) begin
        acc <= div_acc;
      end else begin
        acc    <= mul_acc;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end else if (state == FIX) begin
      out_result <= fix_result;
    end
  end

endmodule

// File: tb/tb_execute_mdu_seq.sv
// tb_execute_mdu_seq: directed + small random scoreboard bench for execute_mdu_seq.
// Latency expectations follow MDU_EARLY_OUT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_execute_mdu_seq;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b1;
  logic [2:0]       in_op = '0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_ready, out_valid, stall;
  logic [WIDTH-1:0] out_result;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  execute_mdu_seq #(.WIDTH(WIDTH), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .stall(stall)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycles from accept to out_valid for a multiply whose multiplier magnitude is m
  function automatic int mulLat(input logic [WIDTH-1:0] m);
    int k;
    k = WIDTH;
`ifdef MDU_EARLY_OUT_EN
    k = 1;
    for (int i = 0; i < WIDTH; i++) if (m[i]) k = i + 1;
`endif
    return k + 2;
  endfunction

  // Independent reference built from wide SV arithmetic
  function automatic logic [WIDTH-1:0] refModel(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] ea, eb, p;
    logic               ovf;
    logic [WIDTH-1:0]   r;
    ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    ea  = (op == 3'd1 || op == 3'd2) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb  = (op == 3'd1) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    p   = ea * eb;
    case (op)
      3'd0:    r = p[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: r = p[2*WIDTH-1:WIDTH];
      3'd4:    r = (b == '0) ? '1 : ovf ? a : WIDTH'($signed(a) / $signed(b));
      3'd5:    r = (b == '0) ? '1 : a / b;
      3'd6:    r = (b == '0) ? a : ovf ? '0 : WIDTH'($signed(a) % $signed(b));
      default: r = (b == '0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] exp, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    exp_q.push_back(exp);
    #1;
    check({tag, "_in_ready"}, WIDTH'(in_ready), WIDTH'(1));
    check({tag, "_stall_offer"}, WIDTH'(stall), WIDTH'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int lat);
    int               cyc;
    logic [WIDTH-1:0] exp;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      check({tag, "_stall_busy"}, WIDTH'(stall), WIDTH'(1));
      @(posedge clk);
      #1;
      cyc++;
    end
    if (lat > 0) check({tag, "_latency"}, WIDTH'(cyc), WIDTH'(lat));
    check({tag, "_out_valid"}, WIDTH'(out_valid), WIDTH'(1));
    exp = 'x;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check({tag, "_result"}, out_result, exp);
    check({tag, "_stall_done"}, WIDTH'(stall), WIDTH'(0));
  endtask

  task automatic completeHandshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, WIDTH'(out_valid), WIDTH'(0));
    check({tag, "_idle"}, WIDTH'(in_ready), WIDTH'(1));
  endtask

  task automatic runOp(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp, input int lat, input string tag);
    applyStimulus(op, a, b, exp, tag);
    checkOutput(tag, lat);
    completeHandshake(tag);
  endtask

  // Directed sequence followed by a few random ops against the reference model
  initial begin
    int seen;
    logic [2:0]       rop;
    logic [WIDTH-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    check("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("rst_out_result", out_result, '0);
    check("rst_stall", WIDTH'(stall), WIDTH'(0));
    reset = 1'b1;

    runOp(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, "mul");
    runOp(3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, "mulhu");
    runOp(3'd1, '1, 64'd1, '1, mulLat(64'd1), "mulh");
    runOp(3'd2, '1, 64'd2, '1, mulLat(64'd2), "mulhsu");
    runOp(3'd4, -64'd20, 64'd3, -64'd6, 66, "div");
    runOp(3'd6, -64'd20, 64'd3, -64'd2, 66, "rem");
    runOp(3'd5, 64'd20, 64'd3, 64'd6, 66, "divu");
    runOp(3'd7, 64'd20, 64'd3, 64'd2, 66, "remu");
    runOp(3'd5, 64'd5, 64'd0, '1, 1, "divu_zero");
    runOp(3'd7, 64'd5, 64'd0, 64'd5, 1, "remu_zero");
    runOp(3'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div_ovf");
    runOp(3'd6, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "rem_ovf");

    $display("[TB] flush during divide");
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd4; in_a = 64'd100; in_b = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("flush_idle", WIDTH'(in_ready), WIDTH'(1));
    check("flush_stall", WIDTH'(stall), WIDTH'(0));
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_output", WIDTH'(seen), WIDTH'(0));
    runOp(3'd0, 64'd2, 64'd3, 64'd6, mulLat(64'd3), "mul_after_flush");

    $display("[TB] flush with in_valid");
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = 64'd5; in_b = 64'd5; flush = 1'b1;
    #1;
    check("flushin_stall", WIDTH'(stall), WIDTH'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flushin_not_taken", WIDTH'(in_ready), WIDTH'(1));

    $display("[TB] reset mid-operation");
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = '1; in_b = '1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("midrst_in_ready", WIDTH'(in_ready), WIDTH'(1));
    check("midrst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("midrst_out_result", out_result, '0);
    check("midrst_stall", WIDTH'(stall), WIDTH'(0));
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", WIDTH'(seen), WIDTH'(0));

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(3'd7, 64'd20, 64'd3, 64'd2, "bp");
    checkOutput("bp", 66);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_result", out_result, 64'd2);
      check("bp_hold_valid", WIDTH'(out_valid), WIDTH'(1));
      check("bp_hold_in_ready", WIDTH'(in_ready), WIDTH'(0));
    end
    completeHandshake("bp");
    runOp(3'd0, 64'd9, 64'd1, 64'd9, mulLat(64'd1), "mul_9x1");

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = i[0] ? {$urandom, $urandom} : {32'd0, 16'd0, 16'($urandom)};
      if (i == 5) rb = '0;
      applyStimulus(rop, ra, rb, refModel(rop, ra, rb), "rand");
      checkOutput("rand", 0);
      completeHandshake("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
